// File: rtl/bdd_traversal_ctrl.sv
// Decision-tree traversal sequencer: walks one feature vector from the root node to a leaf,
// fetching node coefficients and children, requesting a MAC sum and branching on the threshold.
module bdd_traversal_ctrl #(
    parameter int ADDR_W    = 6,
    parameter int MAC_W     = 18,
    parameter int MAX_DEPTH = 16,
    parameter int ROOT_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [39:0]       feat_in,
    output logic              busy,
    output logic              done,
    output logic [8:0]        class_out,
    output logic              err_depth,
    output logic              err_addr,
    output logic [ADDR_W-1:0] node_addr,
    output logic              mem_rd_en,
    input  logic [47:0]       coef_data,
    input  logic [17:0]       child_data,
    output logic              mac_start,
    output logic [39:0]       mac_coef,
    output logic [39:0]       mac_feat,
    input  logic              mac_valid,
    input  logic [MAC_W-1:0]  mac_result
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_MEM,
        S_MAC_ISSUE,
        S_MAC_WAIT,
        S_DECIDE,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] ROOT        = ADDR_W'(ROOT_ADDR);
    localparam logic [8:0]        DEPTH_LIMIT = 9'(MAX_DEPTH);
    localparam logic [8:0]        ERR_WORD    = 9'h1FF;

    state_t             state_reg, state_next;
    logic [39:0]        feat_reg, feat_next;
    logic [39:0]        coef_reg, coef_next;
    logic [7:0]         thr_reg, thr_next;
    logic [8:0]         left_reg, left_next;
    logic [8:0]         right_reg, right_next;
    logic [MAC_W-1:0]   result_reg, result_next;
    logic [7:0]         depth_reg, depth_next;
    logic [ADDR_W-1:0]  node_addr_reg, node_addr_next;
    logic [8:0]         class_reg, class_next;
    logic               err_depth_reg, err_depth_next;
    logic               err_addr_reg, err_addr_next;

    logic               take_right;
    logic [8:0]         sel_word;
    logic               range_bad;
    logic [ADDR_W-1:0]  sel_addr;
    logic [8:0]         depth_inc;

    // Ties go right: only a strictly smaller sum selects the left child.
    assign take_right = (result_reg >= MAC_W'(thr_reg));
    assign sel_word   = take_right ? right_reg : left_reg;
    assign depth_inc  = {1'b0, depth_reg} + 9'd1;

    // Pointer bits above the SRAM address range only exist when ADDR_W < 8.
    generate
        if (ADDR_W < 8) begin : g_range_chk
            assign range_bad = |sel_word[7:ADDR_W];
            assign sel_addr  = sel_word[ADDR_W-1:0];
        end else begin : g_no_range_chk
            assign range_bad = 1'b0;
            assign sel_addr  = ADDR_W'(sel_word[7:0]);
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        feat_next      = feat_reg;
        coef_next      = coef_reg;
        thr_next       = thr_reg;
        left_next      = left_reg;
        right_next     = right_reg;
        result_next    = result_reg;
        depth_next     = depth_reg;
        node_addr_next = node_addr_reg;
        class_next     = class_reg;
        err_depth_next = err_depth_reg;
        err_addr_next  = err_addr_reg;

        if (abort) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        feat_next      = feat_in;
                        node_addr_next = ROOT;
                        depth_next     = 8'd0;
                        class_next     = 9'd0;
                        err_depth_next = 1'b0;
                        err_addr_next  = 1'b0;
                        state_next     = S_FETCH;
                    end
                end
                S_FETCH: state_next = S_WAIT_MEM;
                S_WAIT_MEM: begin
                    coef_next  = coef_data[47:8];
                    thr_next   = coef_data[7:0];
                    left_next  = child_data[17:9];
                    right_next = child_data[8:0];
                    state_next = S_MAC_ISSUE;
                end
                S_MAC_ISSUE: state_next = S_MAC_WAIT;
                S_MAC_WAIT: begin
                    if (mac_valid) begin
                        result_next = mac_result;
                        state_next  = S_DECIDE;
                    end
                end
                S_DECIDE: begin
                    if (sel_word[8]) begin
                        class_next = sel_word;
                        state_next = S_DONE;
                    end else if (range_bad) begin
                        err_addr_next = 1'b1;
                        class_next    = ERR_WORD;
                        state_next    = S_DONE;
                    end else begin
                        depth_next = depth_inc[7:0];
                        if (depth_inc == DEPTH_LIMIT) begin
                            err_depth_next = 1'b1;
                            class_next     = ERR_WORD;
                            state_next     = S_DONE;
                        end else begin
                            node_addr_next = sel_addr;
                            state_next     = S_FETCH;
                        end
                    end
                end
                S_DONE:  state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            feat_reg      <= '0;
            coef_reg      <= '0;
            thr_reg       <= '0;
            left_reg      <= '0;
            right_reg     <= '0;
            result_reg    <= '0;
            depth_reg     <= '0;
            node_addr_reg <= ROOT;
            class_reg     <= '0;
            err_depth_reg <= 1'b0;
            err_addr_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            feat_reg      <= feat_next;
            coef_reg      <= coef_next;
            thr_reg       <= thr_next;
            left_reg      <= left_next;
            right_reg     <= right_next;
            result_reg    <= result_next;
            depth_reg     <= depth_next;
            node_addr_reg <= node_addr_next;
            class_reg     <= class_next;
            err_depth_reg <= err_depth_next;
            err_addr_reg  <= err_addr_next;
        end
    end

    assign busy      = (state_reg != S_IDLE);
    assign done      = (state_reg == S_DONE);
    assign mem_rd_en = (state_reg == S_FETCH);
    assign mac_start = (state_reg == S_MAC_ISSUE);
    assign node_addr = node_addr_reg;
    assign class_out = class_reg;
    assign err_depth = err_depth_reg;
    assign err_addr  = err_addr_reg;
    assign mac_coef  = coef_reg;
    assign mac_feat  = feat_reg;

endmodule
